// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared encodings and defaults for the hazard controller
package core_pkg;

    localparam int REG_AW_DEFAULT = 3;

    // Forwarding select encodings seen by the EX stage operand muxes
    localparam logic [1:0] FW_REG = 2'd0;
    localparam logic [1:0] FW_MEM = 2'd1;
    localparam logic [1:0] FW_WB  = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hz_state_e;

endpackage

// File: rtl/fw_match.sv
// rtl/fw_match.sv - per-source forwarding comparator against the EX/MEM scoreboard
module fw_match
    import core_pkg::*;
#(
    parameter int AW = REG_AW_DEFAULT
) (
    input  logic [AW-1:0] src,
    input  logic          src_used,
    input  logic [AW-1:0] ex_dest,
    input  logic          ex_wb,
    input  logic [AW-1:0] mem_dest,
    input  logic          mem_wb,
    output logic [1:0]    sel
);

    // Younger EX producer wins over MEM; r0 is hardwired and never forwarded
    always_comb begin
        sel = FW_REG;
        if (src_used && (src != '0)) begin
            if (ex_wb && (src == ex_dest)) begin
                sel = FW_MEM;
            end else if (mem_wb && (src == mem_dest)) begin
                sel = FW_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use/flush/mem-wait sequencing and EX forwarding selects
// Optional feature: HAZARD_PERF_CNT_EN adds saturating stall_cnt / flush_cnt_total ports.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEFAULT,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src1_used,
    input  logic              id_src2_used,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_load,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic [1:0]        forwarding_sel_1,
    output logic [1:0]        forwarding_sel_2,
    output logic              freeze_front,
    output logic              freeze_back,
    output logic              bubble_ex,
    output logic              flush_if_id
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt_total
`endif
);

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

    hz_state_e         state_q, state_d, eff_state;
    logic [1:0]        flush_cnt_q, flush_cnt_d;

    logic [REG_AW-1:0] ex_dest_q, ex_dest_d;
    logic              ex_wb_q, ex_wb_d;
    logic              ex_load_q, ex_load_d;
    logic [REG_AW-1:0] mem_dest_q, mem_dest_d;
    logic              mem_wb_q, mem_wb_d;

    logic [1:0]        sel1_q, sel1_d;
    logic [1:0]        sel2_q, sel2_d;
    logic [1:0]        fw_sel1, fw_sel2;

    logic              id_writes;
    logic              load_use;

    fw_match #(.AW(REG_AW)) u_fw_match_1 (
        .src      (id_src1),
        .src_used (id_src1_used),
        .ex_dest  (ex_dest_q),
        .ex_wb    (ex_wb_q),
        .mem_dest (mem_dest_q),
        .mem_wb   (mem_wb_q),
        .sel      (fw_sel1)
    );

    fw_match #(.AW(REG_AW)) u_fw_match_2 (
        .src      (id_src2),
        .src_used (id_src2_used),
        .ex_dest  (ex_dest_q),
        .ex_wb    (ex_wb_q),
        .mem_dest (mem_dest_q),
        .mem_wb   (mem_wb_q),
        .sel      (fw_sel2)
    );

    // A load in EX whose result the ID instruction needs cannot be forwarded in time
    always_comb begin
        id_writes = id_wb_en && (id_dest != '0);
        load_use  = ex_load_q && ex_wb_q &&
                    ((fw_sel1 == FW_MEM) || (fw_sel2 == FW_MEM));
    end

    // Leaving MEM_WAIT behaves like the state that was interrupted: pending flush resumes
    always_comb begin
        eff_state = state_q;
        if (state_q == ST_MEM_WAIT) begin
            eff_state = (flush_cnt_q != 2'd0) ? ST_FLUSH : ST_RUN;
        end
    end

    // Control outputs and next state; mem_busy > load-use > branch_taken
    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        freeze_front = 1'b0;
        freeze_back  = 1'b0;
        bubble_ex    = 1'b0;
        flush_if_id  = 1'b0;
        if (mem_busy) begin
            freeze_front = 1'b1;
            freeze_back  = 1'b1;
            state_d      = ST_MEM_WAIT;
        end else begin
            state_d = eff_state;
            if (load_use) begin
                freeze_front = 1'b1;
                bubble_ex    = 1'b1;
            end
            case (eff_state)
                ST_FLUSH: begin
                    flush_if_id = 1'b1;
                    if (flush_cnt_q <= 2'd1) begin
                        // Last flush cycle: a fresh taken branch restarts the window
                        if (branch_taken && !load_use) begin
                            state_d     = ST_FLUSH;
                            flush_cnt_d = FLUSH_LOAD;
                        end else begin
                            state_d     = ST_RUN;
                            flush_cnt_d = 2'd0;
                        end
                    end else begin
                        flush_cnt_d = flush_cnt_q - 2'd1;
                    end
                end
                default: begin
                    if (branch_taken && !load_use) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end
                end
            endcase
        end
    end

    // Scoreboard shift and forwarding select capture when the back end advances
    always_comb begin
        ex_dest_d  = ex_dest_q;
        ex_wb_d    = ex_wb_q;
        ex_load_d  = ex_load_q;
        mem_dest_d = mem_dest_q;
        mem_wb_d   = mem_wb_q;
        sel1_d     = sel1_q;
        sel2_d     = sel2_q;
        if (!freeze_back) begin
            mem_dest_d = ex_dest_q;
            mem_wb_d   = ex_wb_q;
            if (bubble_ex) begin
                ex_dest_d = '0;
                ex_wb_d   = 1'b0;
                ex_load_d = 1'b0;
                sel1_d    = FW_REG;
                sel2_d    = FW_REG;
            end else begin
                ex_dest_d = id_dest;
                ex_wb_d   = id_writes;
                ex_load_d = id_writes && id_load;
                sel1_d    = fw_sel1;
                sel2_d    = fw_sel2;
            end
        end
    end

    // State, flush counter, scoreboard and select registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 2'd0;
            ex_dest_q   <= '0;
            ex_wb_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_dest_q  <= '0;
            mem_wb_q    <= 1'b0;
            sel1_q      <= FW_REG;
            sel2_q      <= FW_REG;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            ex_dest_q   <= ex_dest_d;
            ex_wb_q     <= ex_wb_d;
            ex_load_q   <= ex_load_d;
            mem_dest_q  <= mem_dest_d;
            mem_wb_q    <= mem_wb_d;
            sel1_q      <= sel1_d;
            sel2_q      <= sel2_d;
        end
    end

    assign forwarding_sel_1 = sel1_q;
    assign forwarding_sel_2 = sel2_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_total_q, flush_total_d;

    // Saturating event counters; freeze_front covers both load-use and mem-wait stalls
    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        flush_total_d = flush_total_q;
        if (freeze_front && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (flush_if_id && (flush_total_q != 16'hFFFF)) begin
            flush_total_d = flush_total_q + 16'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q   <= 16'd0;
            flush_total_q <= 16'd0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            flush_total_q <= flush_total_d;
        end
    end

    assign stall_cnt       = stall_cnt_q;
    assign flush_cnt_total = flush_total_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard-driven bench for hazard_ctrl with FLUSH_CYCLES=2
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_src1, id_src2, id_dest;
    logic       id_src1_used, id_src2_used, id_wb_en, id_load;
    logic       branch_taken, mem_busy;
    logic [1:0] forwarding_sel_1, forwarding_sel_2;
    logic       freeze_front, freeze_back, bubble_ex, flush_if_id;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt_total;
`endif

    hazard_ctrl #(.REG_AW(3), .FLUSH_CYCLES(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_src1          (id_src1),
        .id_src2          (id_src2),
        .id_src1_used     (id_src1_used),
        .id_src2_used     (id_src2_used),
        .id_dest          (id_dest),
        .id_wb_en         (id_wb_en),
        .id_load          (id_load),
        .branch_taken     (branch_taken),
        .mem_busy         (mem_busy),
        .forwarding_sel_1 (forwarding_sel_1),
        .forwarding_sel_2 (forwarding_sel_2),
        .freeze_front     (freeze_front),
        .freeze_back      (freeze_back),
        .bubble_ex        (bubble_ex),
        .flush_if_id      (flush_if_id)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt        (stall_cnt),
        .flush_cnt_total  (flush_cnt_total)
`endif
    );

    always #5 clk = ~clk;

    wire [3:0] ctl  = {freeze_front, freeze_back, bubble_ex, flush_if_id};
    wire [3:0] sels = {forwarding_sel_1, forwarding_sel_2};

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    typedef struct packed {
        logic [2:0] s1; logic u1; logic [2:0] s2; logic u2;
        logic [2:0] d;  logic wb; logic ld;
        logic [1:0] e1; logic [1:0] e2;
    } step_t;

    task automatic drive(input logic [2:0] s1, input logic u1, input logic [2:0] s2,
                         input logic u2, input logic [2:0] d, input logic wb, input logic ld);
        id_src1 = s1; id_src1_used = u1; id_src2 = s2; id_src2_used = u2;
        id_dest = d;  id_wb_en = wb;     id_load = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; branch_taken = 1'b0; mem_busy = 1'b0;
        drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({sels, ctl} !== 8'h00) begin
            failures++; $display("FAIL reset_outputs got=%b exp=%b", {sels, ctl}, 8'h00);
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if ({stall_cnt, flush_cnt_total} !== 32'd0) begin
            failures++; $display("FAIL reset_counters got=%h exp=0", {stall_cnt, flush_cnt_total});
        end
`endif
        tick();
    endtask

    task automatic test_forwarding();
        step_t tbl [9];
        logic [3:0] e;
        tbl[0] = '{3'd2, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0, 2'd0, 2'd0};
        tbl[1] = '{3'd1, 1'b1, 3'd4, 1'b1, 3'd2, 1'b1, 1'b0, 2'd1, 2'd0};
        tbl[2] = '{3'd1, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 2'd2, 2'd0};
        tbl[3] = '{3'd1, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 2'd0, 2'd0};
        tbl[4] = '{3'd5, 1'b0, 3'd5, 1'b0, 3'd5, 1'b1, 1'b0, 2'd0, 2'd0};
        tbl[5] = '{3'd5, 1'b1, 3'd5, 1'b1, 3'd6, 1'b1, 1'b0, 2'd1, 2'd1};
        tbl[6] = '{3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1, 2'd0, 2'd0};
        tbl[7] = '{3'd0, 1'b1, 3'd0, 1'b1, 3'd3, 1'b1, 1'b0, 2'd0, 2'd0};
        tbl[8] = '{3'd3, 1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0, 2'd1, 2'd0};
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].s1, tbl[i].u1, tbl[i].s2, tbl[i].u2, tbl[i].d, tbl[i].wb, tbl[i].ld);
            exp_q.push_back({tbl[i].e1, tbl[i].e2});
            @(negedge clk);
            checks++;
            if (ctl !== 4'b0000) begin
                failures++; $display("FAIL fwd_ctl step=%0d got=%b exp=0000", i, ctl);
            end
            tick();
            e = exp_q.pop_front();
            checks++;
            if (sels !== e) begin
                failures++; $display("FAIL fwd_sel step=%0d got=%b exp=%b", i, sels, e);
            end
        end
    endtask

    task automatic test_load_use_branch();
        logic [3:0] e;
        drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
        exp_q.push_back(4'b0000);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (sels !== e) begin
            failures++; $display("FAIL load_sel got=%b exp=%b", sels, e);
        end
        drive(3'd1, 1'b1, 3'd3, 1'b1, 3'd7, 1'b1, 1'b0);
        branch_taken = 1'b1;
        exp_q.push_back(4'b0000);
        @(negedge clk);
        checks++;
        if (ctl !== 4'b1010) begin
            failures++; $display("FAIL load_use_stall got=%b exp=1010", ctl);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (sels !== e) begin
            failures++; $display("FAIL bubble_sel got=%b exp=%b", sels, e);
        end
        exp_q.push_back(4'b0010);
        @(negedge clk);
        checks++;
        if (ctl !== 4'b0000) begin
            failures++; $display("FAIL branch_ignored_in_stall got=%b exp=0000", ctl);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (sels !== e) begin
            failures++; $display("FAIL load_fwd_sel2 got=%b exp=%b", sels, e);
        end
        branch_taken = 1'b0;
        drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ctl !== ((i < 2) ? 4'b0001 : 4'b0000)) begin
                failures++; $display("FAIL flush_window cyc=%0d got=%b exp=%b", i, ctl,
                                     (i < 2) ? 4'b0001 : 4'b0000);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_ctl [6];
        logic       br [6];
        exp_ctl = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        br      = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            branch_taken = br[i];
            @(negedge clk);
            checks++;
            if (ctl !== exp_ctl[i]) begin
                failures++; $display("FAIL back_to_back cyc=%0d got=%b exp=%b", i, ctl, exp_ctl[i]);
            end
            tick();
        end
        branch_taken = 1'b0;
    endtask

    task automatic test_mem_wait_flush();
        logic [3:0] e;
        drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (ctl !== 4'b0001) begin
            failures++; $display("FAIL mw_first_flush got=%b exp=0001", ctl);
        end
        tick();
        mem_busy = 1'b1;
        drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ctl !== 4'b1100) begin
                failures++; $display("FAIL mem_wait cyc=%0d got=%b exp=1100", i, ctl);
            end
            tick();
        end
        mem_busy = 1'b0;
        drive(3'd6, 1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b0);
        exp_q.push_back(4'b0001);
        @(negedge clk);
        checks++;
        if (ctl !== 4'b0001) begin
            failures++; $display("FAIL mw_flush_resume got=%b exp=0001", ctl);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (sels !== e) begin
            failures++; $display("FAIL mw_scoreboard_sel got=%b exp=%b", sels, e);
        end
        drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (ctl !== 4'b0000) begin
            failures++; $display("FAIL mw_back_to_run got=%b exp=0000", ctl);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1);
        tick();
        drive(3'd4, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (ctl !== 4'b1010) begin
            failures++; $display("FAIL pre_reset_stall got=%b exp=1010", ctl);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({sels, ctl} !== 8'h00) begin
            failures++; $display("FAIL reset_mid_stall got=%b exp=%b", {sels, ctl}, 8'h00);
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if ({stall_cnt, flush_cnt_total} !== 32'd0) begin
            failures++; $display("FAIL reset_mid_counters got=%h exp=0", {stall_cnt, flush_cnt_total});
        end
`endif
        tick();
        drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== 4'b0001) begin
            failures++; $display("FAIL pre_reset_flush got=%b exp=0001", ctl);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== 4'b0000) begin
            failures++; $display("FAIL reset_mid_flush got=%b exp=0000", ctl);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use_branch();
        test_back_to_back();
        test_mem_wait_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
